// File: rtl/pe_cfg_loader.sv
// pe_cfg_loader: configuration sequencer for a row of PEs.
//   After an accepted start it soft-resets the PE row for one cycle. It then
//   streams NUM_PE*cfg_len PE-major instruction beats onto a shared
//   instruction bus, with a one-hot init strobe per beat. After one gap
//   cycle it broadcasts run for exactly cfg_len cycles.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, cfg_len    load-and-run request; cfg_len (1..DEPTH) is sampled with start
//   in_valid/in_ready instruction beat handshake; in_ready is combinational from state
//   in_inst           instruction beat
//   pe_rst            one-cycle soft reset to the PE row
//   pe_inst, pe_init  shared instruction bus and one-hot per-PE init strobe
//   pe_run            run broadcast
//   busy, done, err   sequence in progress, end-of-sequence pulse, rejected-start pulse
//
// Optional feature (macro PE_CFG_LOADER_PERF_EN):
//   load_stall_cnt    LOAD cycles with in_valid low
//   seq_cycle_cnt     cycles from leaving IDLE through DONE
module pe_cfg_loader #(
  parameter int unsigned INST_W = 28,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              pe_rst,
  output logic [INST_W-1:0] pe_inst,
  output logic [NUM_PE-1:0] pe_init,
  output logic              pe_run,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PE_CFG_LOADER_PERF_EN
  ,
  output logic [31:0]       load_stall_cnt,
  output logic [31:0]       seq_cycle_cnt
`endif
);

  localparam int unsigned PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_GAP,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    ctx_idx, ctx_idx_d;
  logic [LEN_W-1:0]    run_cnt, run_cnt_d;
  logic [PE_IDX_W-1:0] pe_idx, pe_idx_d;

  logic                pe_rst_d, pe_run_d, busy_d, done_d, err_d;
  logic [INST_W-1:0]   pe_inst_d;
  logic [NUM_PE-1:0]   pe_init_d;

  logic                xfer, len_ok, last_ctx, last_pe, last_run;

  // Handshake and length qualification
  assign in_ready = (state == S_LOAD);
  assign xfer     = in_valid && in_ready;
  assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
  assign last_ctx = (ctx_idx == len_q - LEN_W'(1));
  assign last_pe  = (pe_idx == PE_IDX_W'(NUM_PE - 1));
  assign last_run = (run_cnt == len_q - LEN_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, counters and registered-output next values
  always_comb begin
    state_d   = state;
    len_d     = len_q;
    ctx_idx_d = ctx_idx;
    pe_idx_d  = pe_idx;
    run_cnt_d = run_cnt;
    pe_inst_d = pe_inst;
    pe_init_d = '0;
    err_d     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d     = cfg_len;
            ctx_idx_d = '0;
            pe_idx_d  = '0;
            run_cnt_d = '0;
            state_d   = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (xfer) begin
          pe_inst_d = in_inst;
          pe_init_d = NUM_PE'(1) << pe_idx;
          if (last_ctx) begin
            ctx_idx_d = '0;
            if (last_pe) begin
              pe_idx_d = '0;
              state_d  = S_GAP;
            end else begin
              pe_idx_d = pe_idx + PE_IDX_W'(1);
            end
          end else begin
            ctx_idx_d = ctx_idx + LEN_W'(1);
          end
        end
      end
      S_GAP: state_d = S_RUN;
      S_RUN: begin
        if (last_run) begin
          run_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          run_cnt_d = run_cnt + LEN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // pe_rst/pe_run/busy track the state being entered so they line up with it;
    // done registers the DONE state, landing with busy's fall.
    pe_rst_d = (state_d == S_CLEAR);
    pe_run_d = (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state == S_DONE);
  end

  // Counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      ctx_idx <= '0;
      pe_idx  <= '0;
      run_cnt <= '0;
      pe_rst  <= 1'b0;
      pe_inst <= '0;
      pe_init <= '0;
      pe_run  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      len_q   <= len_d;
      ctx_idx <= ctx_idx_d;
      pe_idx  <= pe_idx_d;
      run_cnt <= run_cnt_d;
      pe_rst  <= pe_rst_d;
      pe_inst <= pe_inst_d;
      pe_init <= pe_init_d;
      pe_run  <= pe_run_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

`ifdef PE_CFG_LOADER_PERF_EN
  // Performance counters: cleared on an accepted start, held after DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_stall_cnt <= '0;
      seq_cycle_cnt  <= '0;
    end else if (state == S_IDLE && start && len_ok) begin
      load_stall_cnt <= '0;
      seq_cycle_cnt  <= '0;
    end else begin
      if (state == S_LOAD && !in_valid) begin
        load_stall_cnt <= load_stall_cnt + 32'd1;
      end
      if (state != S_IDLE) begin
        seq_cycle_cnt <= seq_cycle_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Self-checking bench for pe_cfg_loader: the stimulus pushes the expected
// event stream of each sequence into a scoreboard. A negedge monitor pops
// and compares every pe_rst, pe_init, pe_run, done and err event the DUT
// presents.
module tb_pe_cfg_loader;

  localparam int unsigned INST_W = 28;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NUM_PE = 4;
  localparam int unsigned LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic              pe_rst;
  logic [INST_W-1:0] pe_inst;
  logic [NUM_PE-1:0] pe_init;
  logic              pe_run;
  logic              busy;
  logic              done;
  logic              err;
`ifdef PE_CFG_LOADER_PERF_EN
  logic [31:0]       load_stall_cnt;
  logic [31:0]       seq_cycle_cnt;
`endif

  pe_cfg_loader #(
    .INST_W(INST_W), .DEPTH(DEPTH), .NUM_PE(NUM_PE), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .pe_rst(pe_rst), .pe_inst(pe_inst), .pe_init(pe_init), .pe_run(pe_run),
    .busy(busy), .done(done), .err(err)
`ifdef PE_CFG_LOADER_PERF_EN
    , .load_stall_cnt(load_stall_cnt), .seq_cycle_cnt(seq_cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {EV_RST, EV_INIT, EV_RUN, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    logic [NUM_PE-1:0] init;
    logic [INST_W-1:0] inst;
  } ev_t;

  ev_t expq[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input logic [NUM_PE-1:0] ini,
                                  input logic [INST_W-1:0] ins);
    ev_t e;
    e.kind = k;
    e.init = ini;
    e.inst = ins;
    expq.push_back(e);
  endfunction

  // Scoreboard compare for one observed event
  task automatic expect_ev(input ev_kind_t k, input logic [NUM_PE-1:0] ini,
                           input logic [INST_W-1:0] ins);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got %s init=%b inst=%h, expected nothing (cycle %0d)",
               k.name(), ini, ins, cyc);
      return;
    end
    e = expq.pop_front();
    if (e.kind != k || (k == EV_INIT && (e.init !== ini || e.inst !== ins))) begin
      bad++;
      $display("FAIL event: got %s init=%b inst=%h, expected %s init=%b inst=%h (cycle %0d)",
               k.name(), ini, ins, e.kind.name(), e.init, e.inst, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (pe_rst)        expect_ev(EV_RST, '0, '0);
      if (pe_init != '0) begin
        expect_ev(EV_INIT, pe_init, pe_inst);
        check("init_run_overlap", 64'(pe_run), 64'(0));
      end
      if (pe_run)        expect_ev(EV_RUN, '0, '0);
      if (done)          expect_ev(EV_DONE, '0, '0);
      if (err)           expect_ev(EV_ERR, '0, '0);
    end
  end

  task automatic check_all_zero(input string name);
    check(name, 64'({pe_rst, pe_init, pe_run, busy, done, err, in_ready, pe_inst}), 64'(0));
`ifdef PE_CFG_LOADER_PERF_EN
    check({name, "_perf"}, 64'({load_stall_cnt, seq_cycle_cnt}), 64'(0));
`endif
  endtask

  task automatic bad_start(input int len);
    push_ev(EV_ERR, '0, '0);
    @(negedge clk);
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    check("bad_err", 64'(err), 64'(1));
    check("bad_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("bad_busy_later", 64'(busy), 64'(0));
    check("bad_sb_empty", 64'(expq.size()), 64'(0));
  endtask

  // vmode: 0 valid held high, 1 toggling 1,0,1,0 per LOAD cycle, 2 random.
  // rst_after > 0 asserts rst once that many beats have been observed.
  task automatic run_seq(input int len, input int vmode, input bit seq_data,
                         input bit poke, input int rst_after);
    logic [INST_W-1:0] insts[$];
    logic [NUM_PE-1:0] oh;
    int   nb, k, s, lc, stalls, bound;
    logic rdy, v;
    bit   got_done, poked;

    nb = NUM_PE * len;
    for (int i = 0; i < nb; i++)
      insts.push_back(seq_data ? INST_W'(i + 1) : INST_W'($urandom));

    // Reference event stream
    push_ev(EV_RST, '0, '0);
    for (int i = 0; i < nb; i++) begin
      oh = '0;
      oh[i / len] = 1'b1;
      push_ev(EV_INIT, oh, insts[i]);
    end
    for (int i = 0; i < len; i++) push_ev(EV_RUN, '0, '0);
    push_ev(EV_DONE, '0, '0);

    @(negedge clk);
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    s       = cyc;
    @(negedge clk);
    start = 1'b0;
    check("rst_latency", 64'(pe_rst), 64'(1));
    check("busy_on", 64'(busy), 64'(1));

    k = 0; lc = 0; stalls = 0; bound = 0;
    while (k < nb) begin
      rdy = in_ready;
      if (rdy) begin
        case (vmode)
          0:       v = 1'b1;
          1:       v = (lc % 2 == 0);
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        lc++;
        if (!v) stalls++;
      end else begin
        v = 1'b0;
      end
      in_valid = v;
      in_inst  = insts[k];
      if (rdy && v) begin
        k++;
        if (k == rst_after) begin
          @(negedge clk);
          #2;
          rst      = 1'b1;
          in_valid = 1'b0;
          #1;
          check_all_zero("midload_rst_outs");
          expq.delete();
          #1;
          rst = 1'b0;
          return;
        end
      end
      @(negedge clk);
      bound++;
      if (bound > 3000) begin
        check("load_timeout_beats", 64'(k), 64'(nb));
        return;
      end
    end
    in_valid = 1'b0;
    check("ready_drop", 64'(in_ready), 64'(0));

    got_done = 1'b0;
    poked    = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (poke && pe_run && !poked) begin
        start   = 1'b1;
        cfg_len = LEN_W'(5);
        poked   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 64'(got_done), 64'(1));
    if (vmode == 0)
      check("done_latency", 64'(cyc - s), 64'(2 + nb + 1 + len + 1));
    check("busy_off", 64'(busy), 64'(0));
    check("inst_hold", 64'(pe_inst), 64'(insts[nb - 1]));
`ifdef PE_CFG_LOADER_PERF_EN
    check("load_stall_cnt", 64'(load_stall_cnt), 64'(stalls));
    check("seq_cycle_cnt", 64'(seq_cycle_cnt), 64'(1 + lc + 1 + len + 1));
`endif
    repeat (4) @(negedge clk);
    check("sb_empty", 64'(expq.size()), 64'(0));
    check("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    cfg_len  = '0;
    in_valid = 1'b0;
    in_inst  = '0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_outs");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bad_start(0);
    bad_start(17);
    run_seq(3, 0, 1'b1, 1'b0, 0);     // basic, beats 1..12
    run_seq(3, 1, 1'b1, 1'b0, 0);     // backpressure 1,0,1,0
    run_seq(16, 0, 1'b0, 1'b0, 0);    // full depth
    run_seq(3, 2, 1'b0, 1'b0, 5);     // reset after beat 5
    run_seq(2, 0, 1'b0, 1'b0, 0);     // recovery
    run_seq(4, 0, 1'b0, 1'b1, 0);     // start poked during RUN
    run_seq(1, 2, 1'b0, 1'b0, 0);     // minimum length
    for (int i = 0; i < 6; i++)
      run_seq($urandom_range(1, 16), 2, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_cfg_loader.md
Name: pe_cfg_loader

Overview:
- Configuration sequencer that sits directly upstream of a row of PEs.
- Accepts a PE-major stream of PE instructions over a valid/ready interface and soft-resets the PE row.
- Writes each PE's configuration buffer using a shared instruction bus and one-hot per-PE init strobes.
- Then asserts run for exactly the loaded number of contexts, so the PEs' run counters never index past their buffer depth.

Parameters:
- INST_W, 28: PE instruction width, matching the PE_inst field layout.
- DEPTH, 16: PE configuration buffer depth (maximum contexts).
- NUM_PE, 4: number of PEs served; one init strobe each.
- LEN_W, 5: width of cfg_len; must satisfy 2^LEN_W > DEPTH.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: one-cycle request to begin a load-and-run sequence.
- cfg_len, input, LEN_W: number of contexts per PE; valid range 1..DEPTH; sampled with start.
- in_valid, input, 1: instruction beat valid.
- in_ready, output, 1: loader accepts beats.
- in_inst, input, INST_W: instruction beat.
- pe_rst, output, 1: synchronous soft reset to the PE row.
- pe_inst, output, INST_W: shared instruction bus to all PEs.
- pe_init, output, NUM_PE: one-hot init strobe per PE.
- pe_run, output, 1: run broadcast to all PEs.
- busy, output, 1: high while the sequence is in progress (state != IDLE).
- done, output, 1: one-cycle pulse at sequence end.
- err, output, 1: one-cycle pulse when start is rejected.

Behaviour:
- Reset: async rst forces state IDLE and all counters to 0.
  - All outputs go to 0 immediately, including pe_inst and in_ready.
  - Reset mid-sequence abandons the load; no done pulse.
- States: IDLE -> CLEAR -> LOAD -> GAP -> RUN -> DONE -> IDLE.
- IDLE
  - start=1 with cfg_len in 1..DEPTH: latch cfg_len, go to CLEAR.
  - start=1 with cfg_len=0 or >DEPTH: pulse err next cycle, stay IDLE.
  - start outside IDLE is ignored: no err, no effect.
- CLEAR: exactly 1 cycle; pe_rst=1 in that cycle. This clears the PE init/run counters and buffers.
- LOAD
  - in_ready=1, combinational from state. A beat transfers when in_valid && in_ready.
  - On a transfer, the registered outputs show the beat in the next cycle: pe_inst=in_inst and pe_init=onehot(pe_idx) for exactly 1 cycle.
  - With no transfer, pe_init=0 and pe_inst holds its last value.
  - Beat order is PE-major: ctx_idx counts 0..cfg_len-1. At wrap, ctx_idx returns to 0 and pe_idx increments.
  - The beat with pe_idx=NUM_PE-1 and ctx_idx=cfg_len-1 is last. It moves the state to GAP, and in_ready drops in the following cycle.
  - Total beats accepted = NUM_PE*cfg_len.
  - in_valid stalls of any length are legal. No timeout.
- GAP: 1 cycle. The last pe_init pulse is visible here. pe_run=0, so init and run never overlap.
- RUN
  - pe_run=1 for exactly cfg_len consecutive cycles, counted by run_cnt; then go to DONE.
  - PE k latches context j on the j-th run cycle.
- DONE: done=1 for 1 cycle; busy falls in the same cycle that state returns to IDLE.
- Latency: start to first pe_rst = 1 cycle. With in_valid held high, start to done = 2 + NUM_PE*cfg_len + 1 + cfg_len + 1 cycles.
- Counter widths: ctx_idx and run_cnt are LEN_W wide; pe_idx is clog2(NUM_PE) wide, minimum 1. No wrap beyond the latched cfg_len.
- All outputs other than in_ready are registered.

Optional Feature:
- Macro: PE_CFG_LOADER_PERF_EN.
- Defined:
  - Adds output load_stall_cnt [31:0]: counts LOAD cycles with in_valid=0.
  - Adds output seq_cycle_cnt [31:0]: counts cycles from leaving IDLE to DONE inclusive.
  - Both are cleared when start is accepted, hold their value after DONE, and are reset to 0 by rst.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Basic load/run: NUM_PE=4, cfg_len=3, in_valid held 1, beats 0x0000001..0x000000C.
  - pe_rst 1 cycle; 12 pe_init pulses in order 0001,0001,0001,0010,...,1000, each carrying the matching pe_inst.
  - One GAP cycle, then pe_run high 3 cycles, then a done pulse. done comes 19 cycles after start.
- Backpressure: same as basic, with in_valid toggling 1,0,1,0.
  - Same 12 pe_init/pe_inst pairs with no duplicates; pe_init=0 on idle cycles.
  - With PE_CFG_LOADER_PERF_EN, load_stall_cnt=11.
- Bad length: start with cfg_len=0, then again with cfg_len=17.
  - err pulses once for each; busy stays 0; no pe_rst, pe_init or pe_run activity.
- Full depth: cfg_len=16, NUM_PE=4.
  - 64 beats accepted; pe_run high exactly 16 cycles; in_ready=0 after the 64th beat.
- Reset mid-load: assert rst asynchronously after beat 5.
  - All outputs 0 immediately, state IDLE; a new start with cfg_len=2 completes normally with 8 beats.
- Start while busy: pulse start during RUN.
  - Ignored: no err, the sequence completes once, single done pulse.
